instr_mem_loader: RTL and testbench

Boot-time writer for the core's instruction memory. Accepts a framed byte stream (from the UART receiver), assembles little-endian 32-bit words, writes them sequentially into the instruction-memory write port starting at byte address 0, verifies an XOR checksum, and holds the core in reset until a frame loads cleanly. It sits between the serial receiver and the instruction memory / core reset, ahead of the single-cycle core.

---
 rtl/instr_mem_loader_if.sv | 28 ++
 rtl/instr_mem_loader.sv | 170 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave: loader side; master: byte source and memory side.
interface instr_mem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot loader: parses A5/N/payload/XOR frames, writes little-endian words to
// instruction memory from address 0 and releases the core on a verified frame.
module instr_mem_loader #(
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic                clk,
  input  logic                rst,
  instr_mem_loader_if.slave   bus,
  output logic                cpu_rst,
  output logic                load_done,
  output logic                err
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam logic [7:0]  MAGIC  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    idx_q, idx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         word_q, word_d;
  logic [7:0]          xor_q, xor_d;
  logic                wr_en_q, wr_en_d;
  logic [WORD_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                rx_ready_q, rx_ready_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                load_done_q, load_done_d;
  logic                err_q, err_d;
  logic                accept;
  logic [LEN_W-1:0]    len_new;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      xor_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      xor_q       <= xor_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rx_ready_q  <= rx_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
    end
  end

  // Frame parser: next state and register updates per accepted byte
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    xor_d     = xor_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    accept    = bus.rx_valid && rx_ready_q;
    len_new   = {bus.rx_data, len_q[7:0]};

    case (state_q)
      IDLE: begin
        if (accept && (bus.rx_data == MAGIC)) begin
          err_d   = 1'b0;
          idx_d   = '0;
          xor_d   = '0;
          bcnt_d  = '0;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d   = {len_q[15:8], bus.rx_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = len_new;
          if ((len_new == '0) || (32'(len_new) > MAX_WORDS)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          xor_d  = xor_q ^ bus.rx_data;
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              // Lane 3 completes the word; emit it straight from the byte bus
              wr_data_d = {bus.rx_data, word_q};
              wr_addr_d = {14'b0, idx_q, 2'b00};
              wr_en_d   = 1'b1;
              idx_d     = idx_q + 16'd1;
              if (idx_q == (len_q - 16'd1)) begin
                state_d = CSUM;
              end
            end
          endcase
        end
      end
      CSUM: begin
        if (accept) begin
          if (bus.rx_data == xor_q) begin
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rx_ready_d  = (state_d != DONE);
    cpu_rst_d   = (state_d != DONE);
    load_done_d = (state_d == DONE);
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_rst      = cpu_rst_q;
  assign load_done    = load_done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized frames for instr_mem_loader, checked against the
// word list each frame was built from.
module tb_instr_mem_loader;
  localparam int unsigned MAX_WORDS = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst;
  logic load_done;
  logic err;

  instr_mem_loader_if bus ();

  instr_mem_loader #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  frame_q[$];
  logic [31:0] words_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic        prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Collect every write and flag back-to-back strobes
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      got_q.push_back({bus.wr_addr, bus.wr_data});
      chk("wr_en_single_cycle", 32'(prev_we), 32'd0);
    end
    prev_we <= (bus.wr_en === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick();
    chk("rst_rx_ready",  32'(bus.rx_ready), 32'd0);
    chk("rst_wr_en",     32'(bus.wr_en),    32'd0);
    chk("rst_wr_addr",   bus.wr_addr,       32'd0);
    chk("rst_wr_data",   bus.wr_data,       32'd0);
    chk("rst_cpu_rst",   32'(cpu_rst),      32'd1);
    chk("rst_load_done", 32'(load_done),    32'd0);
    chk("rst_err",       32'(err),          32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("post_rst_cpu_rst",  32'(cpu_rst),      32'd1);
  endtask

  // Send frame_q; payload (n words) starts at index pay_start, n=0 means none
  task automatic send(input int max_gap, input int pay_start, input int n);
    for (int k = 0; k < frame_q.size(); k++) begin
      int  gap;
      bit  exp_we;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        bus.rx_valid = 1'b0;
        tick();
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = frame_q[k];
      tick();
      bus.rx_valid = 1'b0;
      exp_we = (n > 0) && (k >= pay_start) && (k < pay_start + 4 * n) &&
               (((k - pay_start) % 4) == 3);
      chk("wr_en_latency", 32'(bus.wr_en), 32'(exp_we));
      if (exp_we) chk("wr_addr_latency", bus.wr_addr, 32'(4 * ((k - pay_start) / 4)));
    end
  endtask

  task automatic rand_words(input int n);
    words_q.delete();
    repeat (n) words_q.push_back($urandom);
  endtask

  // Frame from words_q; expected writes are the words at consecutive addresses
  task automatic build(input logic [15:0] nf, input logic [7:0] cbad);
    logic [7:0]  x;
    logic [31:0] w;
    frame_q.delete();
    exp_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(nf[7:0]);
    frame_q.push_back(nf[15:8]);
    x = 8'h00;
    for (int i = 0; i < words_q.size(); i++) begin
      w = words_q[i];
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
      exp_q.push_back({32'(4 * i), w});
    end
    frame_q.push_back(x ^ cbad);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_addr"}, got_q[i][63:32], exp_q[i][63:32]);
      chk({tag, "_data"}, got_q[i][31:0],  exp_q[i][31:0]);
    end
  endtask

  task automatic check_status(input string tag, input bit done, input bit e);
    chk({tag, "_load_done"}, 32'(load_done), 32'(done));
    chk({tag, "_cpu_rst"},   32'(cpu_rst),   32'(!done));
    chk({tag, "_err"},       32'(err),       32'(e));
  endtask

  task automatic directed_exp();
    exp_q.delete();
    exp_q.push_back({32'h0000_0000, 32'h0050_0093});
    exp_q.push_back({32'h0000_0004, 32'h00A0_0113});
  endtask

  initial begin
    logic [15:0] nv;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    do_reset();

    // Good frame back-to-back, then trailing bytes must be ignored
    directed_exp();
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    got_q.delete();
    send(0, 3, 2);
    check_status("good", 1'b1, 1'b0);
    check_writes("good");
    chk("done_rx_ready", 32'(bus.rx_ready), 32'd0);
    frame_q = {8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    got_q.delete();
    send(0, 0, 0);
    chk("done_ignore_writes", 32'(got_q.size()), 32'd0);
    check_status("done_hold", 1'b1, 1'b0);

    // Bad checksum, then resend with correct checksum
    do_reset();
    directed_exp();
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00, 8'h70};
    got_q.delete();
    send(0, 3, 2);
    check_status("badcsum", 1'b0, 1'b1);
    check_writes("badcsum");
    chk("badcsum_rx_ready", 32'(bus.rx_ready), 32'd1);
    frame_q = {8'hA5};
    send(0, 0, 0);
    chk("err_clear_on_magic", 32'(err), 32'd0);
    frame_q = {8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    got_q.delete();
    send(0, 2, 2);
    check_status("resend", 1'b1, 1'b0);
    check_writes("resend");

    // Garbage before magic
    do_reset();
    directed_exp();
    frame_q = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50,
               8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    got_q.delete();
    send(0, 6, 2);
    check_status("garbage", 1'b1, 1'b0);
    check_writes("garbage");

    // Length limits
    do_reset();
    got_q.delete();
    frame_q = {8'hA5, 8'h00, 8'h00};
    send(0, 0, 0);
    check_status("len_zero", 1'b0, 1'b1);
    nv = 16'(MAX_WORDS + 1);
    frame_q = {8'hA5, nv[7:0], nv[15:8]};
    send(0, 0, 0);
    check_status("len_over", 1'b0, 1'b1);
    chk("len_bad_no_writes", 32'(got_q.size()), 32'd0);
    rand_words(int'(MAX_WORDS));
    build(16'(MAX_WORDS), 8'h00);
    got_q.delete();
    send(0, 3, int'(MAX_WORDS));
    check_status("len_max", 1'b1, 1'b0);
    check_writes("len_max");
    if (got_q.size() > 0)
      chk("len_max_last_addr", got_q[got_q.size()-1][63:32], 32'(4 * (MAX_WORDS - 1)));

    // Reset after 6 payload bytes
    do_reset();
    rand_words(2);
    build(16'd2, 8'h00);
    while (frame_q.size() > 9) void'(frame_q.pop_back());
    got_q.delete();
    send(0, 3, 2);
    chk("mid_one_write", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("mid_word0", got_q[0][31:0], words_q[0]);
    do_reset();
    tick();
    chk("mid_no_partial_write", 32'(got_q.size()), 32'd1);
    rand_words(3);
    build(16'd3, 8'h00);
    got_q.delete();
    send(0, 3, 3);
    check_status("after_mid_rst", 1'b1, 1'b0);
    check_writes("after_mid_rst");

    // Throttled directed frame
    do_reset();
    directed_exp();
    frame_q = {8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    got_q.delete();
    send(5, 3, 2);
    check_status("throttled", 1'b1, 1'b0);
    check_writes("throttled");

    // Random frames, some with a corrupted checksum
    for (int it = 0; it < 6; it++) begin
      int n;
      bit bad;
      do_reset();
      n   = int'($urandom_range(1, 8));
      bad = 1'($urandom_range(0, 1));
      rand_words(n);
      build(16'(n), bad ? (8'h01 << $urandom_range(0, 7)) : 8'h00);
      got_q.delete();
      send(5, 3, n);
      check_status("rand", !bad, bad);
      check_writes("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
